bus_cs_controller: RTL and testbench
====================================

# bus_cs_controller

Address-decode and bus-cycle controller that sits between the 8088 pin interface and the memory/IO device modules. It latches the address on ALE and drives a one-hot chip select, per device, from parameterized address windows. It then sequences each read/write cycle and holds READY low for a per-device wait-state count. It is the sole source of the CS vector consumed by the memory/IO devices on the shared bus.

## Interface
Parameters:
- NUM_DEVICES, 4, number of decoded devices (1..8)
- ADDR_WIDTH, 20, bus address width
- WS_WIDTH, 3, wait-state counter width
- BASE[NUM_DEVICES], all 0, window base address per device; must be aligned to its window size
- SIZE_BITS[NUM_DEVICES], all 16, window size = 2^SIZE_BITS bytes
- WAIT_STATES[NUM_DEVICES], all 0, wait states inserted per access (0..2^WS_WIDTH-1)
- IS_IO[NUM_DEVICES], all 0, 1 = device decodes only when IOM=1; 0 = only when IOM=0

Ports:
- CLK  input  1  clock
- RESET  input  1  synchronous, active-high reset
- ALE  input  1  address latch enable, active high
- IOM  input  1  1 = IO cycle, 0 = memory cycle; sampled with ALE
- RD  input  1  read strobe, active low
- WR  input  1  write strobe, active low
- ADDRESS  input  ADDR_WIDTH  bus address; valid while ALE=1
- CS  output  NUM_DEVICES  one-hot chip select, active high
- READY  output  1  1 = cycle may complete; 0 = insert wait
- ERR_CLR  input  1  clears the error flag (see Configuration)
- ERR  output  1  sticky unmapped-access flag
- ERR_ADDR  output  ADDR_WIDTH  address of first unmapped access

## Operation
- Decode: device i hits when IOM==IS_IO[i] and ADDRESS[ADDR_WIDTH-1:SIZE_BITS[i]]==BASE[i][ADDR_WIDTH-1:SIZE_BITS[i]]. On overlapping windows the lowest index wins, so CS is always one-hot or zero.
- CS = decode(ADDRESS,IOM) combinationally while ALE=1, so devices see CS&&ALE in the same cycle. The registered CS_REG drives CS otherwise. CS_REG is loaded at every ALE=1 clock edge.
- FSM states IDLE, ADDR, WAIT, XFER:
  - IDLE: ALE=1 -> ADDR, latching CS_REG and the winning device's WAIT_STATES into WS_CNT.
  - ADDR: RD=0 or WR=0 -> WAIT if WS_CNT>0, else XFER. If RD=0 and WR=0 together, treat as a read. ALE=1 re-latches and stays in ADDR.
  - WAIT: WS_CNT decrements each cycle; at 1 -> XFER.
  - XFER: RD=1 and WR=1 -> IDLE and clear CS_REG.
- ALE=1 in WAIT or XFER aborts the current cycle, re-latches the new address and goes to ADDR.
- An unmapped decode (CS_REG=0) still runs the FSM with 0 wait states. READY stays 1 and no CS is driven.
- READY = 0 exactly in state WAIT, 1 otherwise. READY is registered from the next-state value.

## Timing
- Reset values: state IDLE, CS_REG 0 (CS = 0 unless ALE=1), WS_CNT 0, READY 1, ERR 0, ERR_ADDR 0.
- The first strobe-low edge in ADDR drops READY in the next cycle. READY stays low for exactly WAIT_STATES cycles, then returns to 1.
- CS stays valid from the ALE cycle until the cycle after both strobes return high.
- RESET overrides everything in any state, including mid-wait. It takes effect at the next edge.

## Configuration
- UNMAPPED_ERR_EN defined:
  - An ALE edge with an all-zero decode sets ERR. If ERR was 0, that edge also captures ADDRESS into ERR_ADDR.
  - ERR holds until RESET, or until ERR_CLR=1 at an edge. If a set and a clear land on the same edge, the set wins.
- UNMAPPED_ERR_EN undefined: ERR and ERR_ADDR are tied 0, ERR_CLR is ignored, and no error logic is generated.

## Structure
- Package bus_cs_pkg: the FSM state enum (one-hot, 4 bits), MAX_DEVICES = 8, and a window struct {base, size_bits, wait_states, is_io}.
- Sub-module cs_window_decoder: combinational priority decode of ADDRESS/IOM into a one-hot hit vector plus the winner's wait-state count. The top holds the FSM, counter, registers and error logic.

## Test plan
- Default windows: device 0 at 0x00000 (SIZE_BITS 16, 0 waits), device 1 at 0x10000 (SIZE_BITS 16, 2 waits), device 2 IO at 0x00000 (SIZE_BITS 8, 1 wait), device 3 unused at 0xF0000 (SIZE_BITS 16, 0 waits).
- Read at 0x01234, IOM=0 -> CS=0001 during ALE and until strobes rise; READY never low.
- Write at 0x1ABCD -> CS=0010; READY low for exactly 2 cycles after WR falls, then high; CS cleared one cycle after WR rises.
- IO read at 0x0042, IOM=1 -> CS=0100 (not 0001); READY low for 1 cycle.
- Access to 0xE0000 with UNMAPPED_ERR_EN -> CS=0000, ERR=1, ERR_ADDR=0xE0000. A second unmapped access to 0xE0001 leaves ERR_ADDR at 0xE0000. ERR_CLR=1 -> ERR=0.
- RESET asserted during device 1 WAIT -> next cycle state IDLE, READY=1, CS=0. A new ALE to 0x00010 then gives CS=0001 normally.
- ALE reasserted during XFER with address 0x10000 -> cycle aborted, CS=0010, wait sequence restarts at 2.

Source files
------------

// File: rtl/bus_cs_controller_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : bus_cs_pkg                                                 |
// | Description : Shared types for the 8088 bus chip-select controller:      |
// |               one-hot FSM state encoding, device window descriptor and   |
// |               the window hit helper used by the address decoder.         |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
package bus_cs_pkg;

   localparam int MAX_DEVICES    = 8;
   localparam int MAX_ADDR_WIDTH = 32;
   localparam int MAX_WS_WIDTH   = 8;

   typedef enum logic [3:0] {
      ST_IDLE = 4'b0001,
      ST_ADDR = 4'b0010,
      ST_WAIT = 4'b0100,
      ST_XFER = 4'b1000
   } bus_state_t;

   // Fields are sized for the widest supported configuration; narrower
   // builds zero-extend into them.
   typedef struct packed {
      logic [MAX_ADDR_WIDTH-1:0] base;
      logic [7:0]                size_bits;
      logic [MAX_WS_WIDTH-1:0]   wait_states;
      logic                      is_io;
   } window_t;

   // A window hits when the cycle type matches and every address bit above
   // the window size agrees with the base. Bits above the bus width are
   // masked off so stray high base bits cannot break the compare.
   function automatic logic window_hit(input window_t                   win,
                                       input logic [MAX_ADDR_WIDTH-1:0] addr,
                                       input logic                      iom,
                                       input int                        addr_width);
      logic [MAX_ADDR_WIDTH-1:0] w_keep;
      w_keep = ~((32'd1 << win.size_bits) - 32'd1);
      if (addr_width < MAX_ADDR_WIDTH)
         w_keep = w_keep & ((32'd1 << addr_width) - 32'd1);
      return (iom == win.is_io) && (((addr ^ win.base) & w_keep) == '0);
   endfunction

endpackage
`default_nettype wire

// File: rtl/bus_cs_controller_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : bus_cs_controller_if                                       |
// | Description : 8088-side bus bundle for the chip-select controller.       |
// |               master : CPU/pin side (drives ALE, IOM, RD, WR, ADDRESS,   |
// |                        ERR_CLR; observes CS, READY, ERR, ERR_ADDR)       |
// |               slave  : bus_cs_controller                                 |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
interface bus_cs_controller_if #(
   parameter int NUM_DEVICES = 4,
   parameter int ADDR_WIDTH  = 20
);
   logic                   ALE;
   logic                   IOM;
   logic                   RD;
   logic                   WR;
   logic [ADDR_WIDTH-1:0]  ADDRESS;
   logic [NUM_DEVICES-1:0] CS;
   logic                   READY;
   logic                   ERR_CLR;
   logic                   ERR;
   logic [ADDR_WIDTH-1:0]  ERR_ADDR;

   modport master (
      output ALE, IOM, RD, WR, ADDRESS, ERR_CLR,
      input  CS, READY, ERR, ERR_ADDR
   );

   modport slave (
      input  ALE, IOM, RD, WR, ADDRESS, ERR_CLR,
      output CS, READY, ERR, ERR_ADDR
   );
endinterface
`default_nettype wire

// File: rtl/bus_cs_controller_decoder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : cs_window_decoder                                          |
// | Description : Combinational priority decode of a bus address and cycle   |
// |               type into a one-hot device hit vector. The lowest-index    |
// |               matching window wins; its wait-state count is returned.    |
// |               No hit -> zero vector and zero wait states.                |
// | Ports       : i_address, i_iom -> o_hit, o_wait_states                   |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module cs_window_decoder
   import bus_cs_pkg::*;
#(
   parameter int NUM_DEVICES = 4,
   parameter int ADDR_WIDTH  = 20,
   parameter int WS_WIDTH    = 3,
   parameter logic [NUM_DEVICES-1:0][ADDR_WIDTH-1:0] BASE        = '0,
   parameter logic [NUM_DEVICES-1:0][7:0]            SIZE_BITS   = {NUM_DEVICES{8'd16}},
   parameter logic [NUM_DEVICES-1:0][WS_WIDTH-1:0]   WAIT_STATES = '0,
   parameter logic [NUM_DEVICES-1:0]                 IS_IO       = '0
) (
   input  wire logic [ADDR_WIDTH-1:0]  i_address,
   input  wire logic                   i_iom,
   output logic      [NUM_DEVICES-1:0] o_hit,
   output logic      [WS_WIDTH-1:0]    o_wait_states
);

   window_t                w_win [NUM_DEVICES];
   logic [NUM_DEVICES-1:0] w_raw;

   for (genvar gi = 0; gi < NUM_DEVICES; gi++) begin : g_win
      assign w_win[gi] = '{
         base:        MAX_ADDR_WIDTH'(BASE[gi]),
         size_bits:   SIZE_BITS[gi],
         wait_states: MAX_WS_WIDTH'(WAIT_STATES[gi]),
         is_io:       IS_IO[gi]
      };
      assign w_raw[gi] = window_hit(w_win[gi], MAX_ADDR_WIDTH'(i_address),
                                    i_iom, ADDR_WIDTH);
   end

   // Scan from the highest index down so the lowest matching index is the
   // last one written and therefore the one that survives.
   always_comb begin
      o_hit         = '0;
      o_wait_states = '0;
      for (int i = NUM_DEVICES - 1; i >= 0; i--) begin
         if (w_raw[i]) begin
            o_hit         = '0;
            o_hit[i]      = 1'b1;
            o_wait_states = w_win[i].wait_states[WS_WIDTH-1:0];
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/bus_cs_controller.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : bus_cs_controller                                          |
// | Description : 8088 address decode and bus-cycle controller. Latches the  |
// |               decode on ALE, drives a one-hot CS to the devices and      |
// |               holds READY low for each device's wait-state count.        |
// | Ports       : CLK, RESET (sync, active high)                             |
// |               bus (slave): ALE IOM RD WR ADDRESS ERR_CLR in;             |
// |                            CS READY ERR ERR_ADDR out                     |
// | Options     : UNMAPPED_ERR_EN - sticky unmapped-access flag with the     |
// |               first offending address; otherwise ERR/ERR_ADDR are 0.     |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module bus_cs_controller
   import bus_cs_pkg::*;
#(
   parameter int NUM_DEVICES = 4,
   parameter int ADDR_WIDTH  = 20,
   parameter int WS_WIDTH    = 3,
   parameter logic [NUM_DEVICES-1:0][ADDR_WIDTH-1:0] BASE        = '0,
   parameter logic [NUM_DEVICES-1:0][7:0]            SIZE_BITS   = {NUM_DEVICES{8'd16}},
   parameter logic [NUM_DEVICES-1:0][WS_WIDTH-1:0]   WAIT_STATES = '0,
   parameter logic [NUM_DEVICES-1:0]                 IS_IO       = '0
) (
   input wire logic         CLK,
   input wire logic         RESET,
   bus_cs_controller_if.slave bus
);

   bus_state_t             r_state;
   logic [NUM_DEVICES-1:0] r_cs;
   logic [WS_WIDTH-1:0]    r_ws_cnt;
   logic                   r_ready;

   logic [NUM_DEVICES-1:0] w_hit;
   logic [WS_WIDTH-1:0]    w_ws;
   logic                   w_strobe;
   logic                   w_bus_idle;

   cs_window_decoder #(
      .NUM_DEVICES (NUM_DEVICES),
      .ADDR_WIDTH  (ADDR_WIDTH),
      .WS_WIDTH    (WS_WIDTH),
      .BASE        (BASE),
      .SIZE_BITS   (SIZE_BITS),
      .WAIT_STATES (WAIT_STATES),
      .IS_IO       (IS_IO)
   ) u_decoder (
      .i_address     (bus.ADDRESS),
      .i_iom         (bus.IOM),
      .o_hit         (w_hit),
      .o_wait_states (w_ws)
   );

   // Read and write strobes are treated alike here: both low together is
   // just a (read) strobe, and the cycle sequencing is identical.
   assign w_strobe   = ~bus.RD | ~bus.WR;
   assign w_bus_idle =  bus.RD &  bus.WR;

   // ALE has priority in every state: a new address always restarts the
   // cycle, which also covers aborting out of WAIT or XFER. READY is
   // written alongside the state so it always reflects the next state.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         r_state  <= ST_IDLE;
         r_cs     <= '0;
         r_ws_cnt <= '0;
         r_ready  <= 1'b1;
      end else if (bus.ALE) begin
         r_state  <= ST_ADDR;
         r_cs     <= w_hit;
         r_ws_cnt <= w_ws;
         r_ready  <= 1'b1;
      end else begin
         case (r_state)
            ST_ADDR: begin
               if (w_strobe) begin
                  if (r_ws_cnt != '0) begin
                     r_state <= ST_WAIT;
                     r_ready <= 1'b0;
                  end else begin
                     r_state <= ST_XFER;
                  end
               end
            end
            ST_WAIT: begin
               r_ws_cnt <= r_ws_cnt - WS_WIDTH'(1);
               if (r_ws_cnt == WS_WIDTH'(1)) begin
                  r_state <= ST_XFER;
                  r_ready <= 1'b1;
               end
            end
            ST_XFER: begin
               if (w_bus_idle) begin
                  r_state <= ST_IDLE;
                  r_cs    <= '0;
               end
            end
            default: begin
               // IDLE waiting for ALE; any corrupted encoding falls back here.
               r_state <= ST_IDLE;
               r_ready <= 1'b1;
            end
         endcase
      end
   end

   // Devices qualify CS with ALE in the address cycle, so the live decode is
   // passed straight through while ALE is high.
   assign bus.CS    = bus.ALE ? w_hit : r_cs;
   assign bus.READY = r_ready;

`ifdef UNMAPPED_ERR_EN
   logic                  r_err;
   logic [ADDR_WIDTH-1:0] r_err_addr;

   // A new unmapped access takes precedence over a same-edge clear; only
   // the first offending address since the last clear is recorded.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         r_err      <= 1'b0;
         r_err_addr <= '0;
      end else if (bus.ALE && (w_hit == '0)) begin
         r_err <= 1'b1;
         if (!r_err)
            r_err_addr <= bus.ADDRESS;
      end else if (bus.ERR_CLR) begin
         r_err <= 1'b0;
      end
   end

   assign bus.ERR      = r_err;
   assign bus.ERR_ADDR = r_err_addr;
`else
   assign bus.ERR      = 1'b0;
   assign bus.ERR_ADDR = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_bus_cs_controller.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_bus_cs_controller                                       |
// | Description : Scoreboard bench for bus_cs_controller. Bus transactions   |
// |               are expanded into per-cycle expected CS/READY/ERR values   |
// |               from the window table; a monitor compares every cycle.     |
// |               Honours UNMAPPED_ERR_EN for the error-flag expectations.   |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module tb_bus_cs_controller;

   logic CLK;
   logic RESET;

   bus_cs_controller_if #(.NUM_DEVICES(4), .ADDR_WIDTH(20)) bus ();

   bus_cs_controller #(
      .NUM_DEVICES (4),
      .ADDR_WIDTH  (20),
      .WS_WIDTH    (3),
      .BASE        ({20'hF0000, 20'h00000, 20'h10000, 20'h00000}),
      .SIZE_BITS   ({8'd16, 8'd8, 8'd16, 8'd16}),
      .WAIT_STATES ({3'd0, 3'd1, 3'd2, 3'd0}),
      .IS_IO       (4'b0100)
   ) dut (
      .CLK   (CLK),
      .RESET (RESET),
      .bus   (bus)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // Window table for the reference decode
   int m_base [4] = '{32'h00000, 32'h10000, 32'h00000, 32'hF0000};
   int m_sb   [4] = '{16, 16, 8, 16};
   int m_ws   [4] = '{0, 2, 1, 0};
   int m_io   [4] = '{0, 0, 1, 0};

   typedef struct {
      logic [3:0]  cs;
      logic        ready;
      logic        err;
      logic [19:0] err_addr;
      int          cyc;
   } exp_t;

   exp_t        sb_q [$];
   exp_t        mon_e;
   int          n_checks = 0;
   int          n_fail   = 0;
   int          cyc      = 0;
   logic        m_err      = 1'b0;
   logic [19:0] m_err_addr = '0;

   function automatic logic [3:0] ref_decode(input logic [19:0] a, input bit iom);
      for (int i = 0; i < 4; i++)
         if (m_io[i] == int'(iom) && ((int'(a) >> m_sb[i]) == (m_base[i] >> m_sb[i])))
            return 4'(1 << i);
      return 4'b0000;
   endfunction

   function automatic int ref_waits(input logic [3:0] dev);
      for (int i = 0; i < 4; i++)
         if (dev[i]) return m_ws[i];
      return 0;
   endfunction

   // Drive one clock cycle of bus inputs and queue what the outputs must be
   // during it; then advance the error-flag model across the closing edge.
   task automatic drive_cycle(input bit ale, input bit iom, input bit rd_n, input bit wr_n,
                              input logic [19:0] addr, input bit clr, input bit rst,
                              input logic [3:0] e_cs, input bit e_ready);
      exp_t e;
      @(posedge CLK);
      #1;
      cyc++;
      bus.ALE     = ale;
      bus.IOM     = iom;
      bus.RD      = rd_n;
      bus.WR      = wr_n;
      bus.ADDRESS = addr;
      bus.ERR_CLR = clr;
      RESET       = rst;
      e.cs       = e_cs;
      e.ready    = e_ready;
      e.err      = m_err;
      e.err_addr = m_err_addr;
      e.cyc      = cyc;
      sb_q.push_back(e);
      if (rst) begin
         m_err      = 1'b0;
         m_err_addr = '0;
      end
`ifdef UNMAPPED_ERR_EN
      else if (ale && ref_decode(addr, iom) == 4'b0000) begin
         if (!m_err) m_err_addr = addr;
         m_err = 1'b1;
      end else if (clr) begin
         m_err = 1'b0;
      end
`endif
   endtask

   // One complete bus cycle: ALE, optional address-hold cycles, strobe low
   // through the wait states plus extra, release, then idle cycles.
   task automatic do_txn(input logic [19:0] addr, input bit iom, input bit is_wr,
                         input bit both, input int gap, input int extra, input int idle,
                         input bit clr_ale, input bit clr_idle, input bit no_release);
      logic [3:0] dev;
      int         w;
      bit         rd_n, wr_n;
      dev  = ref_decode(addr, iom);
      w    = ref_waits(dev);
      rd_n = (is_wr && !both);
      wr_n = !(is_wr || both);
      drive_cycle(1'b1, iom, 1'b1, 1'b1, addr, clr_ale, 1'b0, dev, 1'b1);
      repeat (gap) drive_cycle(1'b0, iom, 1'b1, 1'b1, addr, 1'b0, 1'b0, dev, 1'b1);
      drive_cycle(1'b0, iom, rd_n, wr_n, addr, 1'b0, 1'b0, dev, 1'b1);
      repeat (w) drive_cycle(1'b0, iom, rd_n, wr_n, addr, 1'b0, 1'b0, dev, 1'b0);
      if (!no_release) begin
         repeat (extra) drive_cycle(1'b0, iom, rd_n, wr_n, addr, 1'b0, 1'b0, dev, 1'b1);
         drive_cycle(1'b0, iom, 1'b1, 1'b1, addr, 1'b0, 1'b0, dev, 1'b1);
         repeat (idle) drive_cycle(1'b0, iom, 1'b1, 1'b1, addr, clr_idle, 1'b0, 4'b0000, 1'b1);
      end
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv,
                        input int c);
      n_checks++;
      if (act !== expv) begin
         n_fail++;
         $display("FAIL %s cycle %0d: got %h, expected %h", name, c, act, expv);
      end
   endtask

   // Monitor: every cycle that has a queued expectation is compared at the
   // falling edge, away from the register update.
   always @(negedge CLK) begin
      if (sb_q.size() > 0) begin
         mon_e = sb_q.pop_front();
         check("CS",       32'(bus.CS),       32'(mon_e.cs),       mon_e.cyc);
         check("READY",    32'(bus.READY),    32'(mon_e.ready),    mon_e.cyc);
         check("ERR",      32'(bus.ERR),      32'(mon_e.err),      mon_e.cyc);
         check("ERR_ADDR", 32'(bus.ERR_ADDR), 32'(mon_e.err_addr), mon_e.cyc);
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [19:0] a;
      bit          iom;
      int          sel;

      bus.ALE = 1'b0; bus.IOM = 1'b0; bus.RD = 1'b1; bus.WR = 1'b1;
      bus.ADDRESS = '0; bus.ERR_CLR = 1'b0;
      RESET = 1'b1;
      repeat (3) @(posedge CLK);

      // Reset state, then an idle cycle
      drive_cycle(1'b0, 1'b0, 1'b1, 1'b1, 20'h0, 1'b0, 1'b0, 4'b0000, 1'b1);
      drive_cycle(1'b0, 1'b0, 1'b1, 1'b1, 20'h0, 1'b0, 1'b0, 4'b0000, 1'b1);

      // Directed cases
      do_txn(20'h01234, 1'b0, 1'b0, 1'b0, 1, 0, 1, 1'b0, 1'b0, 1'b0); // mem read dev0
      do_txn(20'h1ABCD, 1'b0, 1'b1, 1'b0, 0, 0, 1, 1'b0, 1'b0, 1'b0); // write dev1, 2 waits
      do_txn(20'h00042, 1'b1, 1'b0, 1'b0, 0, 1, 1, 1'b0, 1'b0, 1'b0); // IO read dev2
      do_txn(20'hE0000, 1'b0, 1'b0, 1'b0, 0, 0, 1, 1'b0, 1'b0, 1'b0); // unmapped
      do_txn(20'hE0001, 1'b0, 1'b1, 1'b0, 0, 0, 1, 1'b0, 1'b1, 1'b0); // unmapped, then clear
      drive_cycle(1'b0, 1'b0, 1'b1, 1'b1, 20'h0, 1'b0, 1'b0, 4'b0000, 1'b1);
      do_txn(20'hE0100, 1'b0, 1'b0, 1'b0, 0, 0, 1, 1'b1, 1'b0, 1'b0); // set beats clear
      do_txn(20'hF8000, 1'b0, 1'b0, 1'b1, 0, 0, 1, 1'b0, 1'b1, 1'b0); // dev3, both strobes

      // Reset in the middle of a device-1 wait
      drive_cycle(1'b1, 1'b0, 1'b1, 1'b1, 20'h1ABCD, 1'b0, 1'b0, 4'b0010, 1'b1);
      drive_cycle(1'b0, 1'b0, 1'b1, 1'b0, 20'h1ABCD, 1'b0, 1'b0, 4'b0010, 1'b1);
      drive_cycle(1'b0, 1'b0, 1'b1, 1'b0, 20'h1ABCD, 1'b0, 1'b1, 4'b0010, 1'b0);
      drive_cycle(1'b0, 1'b0, 1'b1, 1'b1, 20'h1ABCD, 1'b0, 1'b0, 4'b0000, 1'b1);
      do_txn(20'h00010, 1'b0, 1'b0, 1'b0, 0, 0, 1, 1'b0, 1'b0, 1'b0);

      // ALE during XFER aborts and restarts with the new window's waits
      do_txn(20'h01234, 1'b0, 1'b0, 1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b1);
      do_txn(20'h10000, 1'b0, 1'b0, 1'b0, 0, 0, 1, 1'b0, 1'b0, 1'b0);

      // Randomized traffic across mapped and unmapped regions
      for (int n = 0; n < 150; n++) begin
         sel = $urandom_range(0, 5);
         case (sel)
            0: begin a = {4'h0, 16'($urandom)}; iom = 1'b0; end
            1: begin a = {4'h1, 16'($urandom)}; iom = 1'b0; end
            2: begin a = {12'h0, 8'($urandom)}; iom = 1'b1; end
            3: begin a = 20'($urandom);         iom = 1'b1; end
            4: begin a = {4'hF, 16'($urandom)}; iom = 1'b0; end
            default: begin a = 20'($urandom);   iom = 1'b0; end
         endcase
         do_txn(a, iom, 1'($urandom), ($urandom_range(0, 7) == 0),
                $urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 2),
                ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) == 0),
                ($urandom_range(0, 9) == 0));
      end

      drive_cycle(1'b0, 1'b0, 1'b1, 1'b1, 20'h0, 1'b0, 1'b0, 4'b0000, 1'b1);

      for (int k = 0; k < 20 && sb_q.size() > 0; k++) @(negedge CLK);
      @(negedge CLK);
      #1;
      if (sb_q.size() > 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL drain: %0d expectations left unchecked, expected 0", sb_q.size());
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
